// File: rtl/paillier_lite_ctrl_regs.sv
// rtl/paillier_lite_ctrl_regs.sv - AXI-Lite control/status register file for the Paillier accelerator
module paillier_lite_ctrl_regs #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                            S_LITE_AXI_ACLK,
    input  logic                            S_LITE_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    input  logic                            engine_busy,
    input  logic                            engine_done,
    output logic                            start,
    output logic [1:0]                      mode,
    output logic [63:0]                     task_count,
    output logic                            irq
);

    localparam logic [1:0] REG_CTRL     = 2'd0;
    localparam logic [1:0] REG_STATUS   = 2'd1;
    localparam logic [1:0] REG_COUNT_LO = 2'd2;
    localparam logic [1:0] REG_COUNT_HI = 2'd3;
    localparam logic [1:0] RESP_OKAY    = 2'b00;
    localparam logic [1:0] RESP_SLVERR  = 2'b10;

    // Write channel state
    logic        awready_q, wready_q;
    logic        aw_full_q, w_full_q;
    logic [1:0]  waddr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic        bvalid_q, bvalid_d;
    logic [1:0]  bresp_q, bresp_d;

    // Read channel state
    logic        arready_q, rvalid_q;
    logic [31:0] rdata_q, rdata_d;

    // Register file
    logic [1:0]  mode_q, mode_d;
    logic        irq_en_q, irq_en_d;
    logic [31:0] count_lo_q, count_lo_d;
    logic [31:0] count_hi_q, count_hi_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        start_q, start_d;
    logic        irq_q;

    logic        wr_commit;
    logic        aw_hs, w_hs, ar_hs;

    // Protection bits and sub-word address bits carry no meaning here
    logic        unused_sigs;
    assign unused_sigs = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    assign aw_hs     = S_AXI_AWVALID && awready_q;
    assign w_hs      = S_AXI_WVALID && wready_q;
    assign ar_hs     = S_AXI_ARVALID && arready_q;
    assign wr_commit = aw_full_q && w_full_q;

    // Accept AW and W independently, one beat each, holding off until the B handshake is done
    always_ff @(posedge S_LITE_AXI_ACLK or posedge S_LITE_AXI_ARESETN) begin
        if (S_LITE_AXI_ARESETN) begin
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            aw_full_q <= 1'b0;
            w_full_q  <= 1'b0;
            waddr_q   <= 2'd0;
            wdata_q   <= 32'd0;
            wstrb_q   <= 4'd0;
        end else begin
            awready_q <= S_AXI_AWVALID && !awready_q && !aw_full_q && !bvalid_q;
            wready_q  <= S_AXI_WVALID && !wready_q && !w_full_q && !bvalid_q;
            if (aw_hs) begin
                aw_full_q <= 1'b1;
                waddr_q   <= S_AXI_AWADDR[3:2];
            end else if (wr_commit) begin
                aw_full_q <= 1'b0;
            end
            if (w_hs) begin
                w_full_q <= 1'b1;
                wdata_q  <= S_AXI_WDATA;
                wstrb_q  <= S_AXI_WSTRB;
            end else if (wr_commit) begin
                w_full_q <= 1'b0;
            end
        end
    end

    // Decode a captured write into register updates, response and launch pulse
    always_comb begin
        mode_d     = mode_q;
        irq_en_d   = irq_en_q;
        count_lo_d = count_lo_q;
        count_hi_d = count_hi_q;
        done_d     = done_q;
        err_d      = err_q;
        start_d    = 1'b0;
        bresp_d    = bresp_q;
        bvalid_d   = bvalid_q;
        if (bvalid_q && S_AXI_BREADY) begin
            bvalid_d = 1'b0;
        end
        if (wr_commit) begin
            bvalid_d = 1'b1;
            bresp_d  = RESP_OKAY;
            case (waddr_q)
                REG_CTRL: begin
                    if (wstrb_q[0]) begin
                        if (engine_busy) begin
                            bresp_d = RESP_SLVERR;
                        end else begin
                            mode_d   = wdata_q[2:1];
                            irq_en_d = wdata_q[3];
                        end
                        if (wdata_q[0]) begin
                            if (engine_busy || ({count_hi_q, count_lo_q} == 64'd0)) begin
                                err_d   = 1'b1;
                                bresp_d = RESP_SLVERR;
                            end else begin
                                start_d = 1'b1;
                                done_d  = 1'b0;
                            end
                        end
                    end
                end
                REG_STATUS: begin
                    if (wstrb_q[0]) begin
                        if (wdata_q[1]) done_d = 1'b0;
                        if (wdata_q[2]) err_d = 1'b0;
                    end
                end
                REG_COUNT_LO: begin
                    if (engine_busy) begin
                        bresp_d = RESP_SLVERR;
                    end else begin
                        for (int b = 0; b < 4; b++) begin
                            if (wstrb_q[b]) count_lo_d[8*b +: 8] = wdata_q[8*b +: 8];
                        end
                    end
                end
                default: begin
                    if (engine_busy) begin
                        bresp_d = RESP_SLVERR;
                    end else begin
                        for (int b = 0; b < 4; b++) begin
                            if (wstrb_q[b]) count_hi_d[8*b +: 8] = wdata_q[8*b +: 8];
                        end
                    end
                end
            endcase
        end
        // A completion in the same cycle as a clear must not be lost
        if (engine_done) begin
            done_d = 1'b1;
        end
    end

    // Register state, write response and one-cycle start pulse
    always_ff @(posedge S_LITE_AXI_ACLK or posedge S_LITE_AXI_ARESETN) begin
        if (S_LITE_AXI_ARESETN) begin
            mode_q     <= 2'd0;
            irq_en_q   <= 1'b0;
            count_lo_q <= 32'd0;
            count_hi_q <= 32'd0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            start_q    <= 1'b0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
        end else begin
            mode_q     <= mode_d;
            irq_en_q   <= irq_en_d;
            count_lo_q <= count_lo_d;
            count_hi_q <= count_hi_d;
            done_q     <= done_d;
            err_q      <= err_d;
            start_q    <= start_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
        end
    end

    // Read mux samples pre-write register values, so a concurrent write is not visible
    always_comb begin
        rdata_d = 32'd0;
        case (S_AXI_ARADDR[3:2])
            REG_CTRL:     rdata_d = {28'd0, irq_en_q, mode_q, 1'b0};
            REG_STATUS:   rdata_d = {29'd0, err_q, done_q, engine_busy};
            REG_COUNT_LO: rdata_d = count_lo_q;
            default:      rdata_d = count_hi_q;
        endcase
    end

    // Single-beat read channel: RDATA is held until RREADY
    always_ff @(posedge S_LITE_AXI_ACLK or posedge S_LITE_AXI_ARESETN) begin
        if (S_LITE_AXI_ARESETN) begin
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= 32'd0;
        end else begin
            arready_q <= S_AXI_ARVALID && !arready_q && !rvalid_q;
            if (ar_hs) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rdata_d;
            end else if (rvalid_q && S_AXI_RREADY) begin
                rvalid_q <= 1'b0;
            end
        end
    end

    // Level interrupt follows DONE gated by IRQ_EN, one cycle behind
    always_ff @(posedge S_LITE_AXI_ACLK or posedge S_LITE_AXI_ARESETN) begin
        if (S_LITE_AXI_ARESETN) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= done_q && irq_en_q;
        end
    end

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = wready_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = RESP_OKAY;
    assign start         = start_q;
    assign mode          = mode_q;
    assign task_count    = {count_hi_q, count_lo_q};
    assign irq           = irq_q;

endmodule

// File: tb/tb_paillier_lite_ctrl_regs.sv
// tb/tb_paillier_lite_ctrl_regs.sv - directed self-checking bench for paillier_lite_ctrl_regs
module tb_paillier_lite_ctrl_regs;

    logic        S_LITE_AXI_ACLK = 1'b0;
    logic        S_LITE_AXI_ARESETN = 1'b1;
    logic [3:0]  S_AXI_AWADDR = '0;
    logic [2:0]  S_AXI_AWPROT = '0;
    logic        S_AXI_AWVALID = 1'b0;
    logic        S_AXI_AWREADY;
    logic [31:0] S_AXI_WDATA = '0;
    logic [3:0]  S_AXI_WSTRB = '0;
    logic        S_AXI_WVALID = 1'b0;
    logic        S_AXI_WREADY;
    logic [1:0]  S_AXI_BRESP;
    logic        S_AXI_BVALID;
    logic        S_AXI_BREADY = 1'b0;
    logic [3:0]  S_AXI_ARADDR = '0;
    logic [2:0]  S_AXI_ARPROT = '0;
    logic        S_AXI_ARVALID = 1'b0;
    logic        S_AXI_ARREADY;
    logic [31:0] S_AXI_RDATA;
    logic [1:0]  S_AXI_RRESP;
    logic        S_AXI_RVALID;
    logic        S_AXI_RREADY = 1'b0;
    logic        engine_busy = 1'b0;
    logic        engine_done = 1'b0;
    logic        start;
    logic [1:0]  mode;
    logic [63:0] task_count;
    logic        irq;

    int pass_cnt = 0;
    int chk_cnt  = 0;
    int start_cnt = 0;
    int start_misaligned = 0;
    logic [1:0] start_mode = '0;
    logic bvalid_prev = 1'b0;

    paillier_lite_ctrl_regs dut (
        .S_LITE_AXI_ACLK(S_LITE_AXI_ACLK), .S_LITE_AXI_ARESETN(S_LITE_AXI_ARESETN),
        .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT), .S_AXI_AWVALID(S_AXI_AWVALID),
        .S_AXI_AWREADY(S_AXI_AWREADY), .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
        .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY), .S_AXI_BRESP(S_AXI_BRESP),
        .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY), .S_AXI_ARADDR(S_AXI_ARADDR),
        .S_AXI_ARPROT(S_AXI_ARPROT), .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP), .S_AXI_RVALID(S_AXI_RVALID),
        .S_AXI_RREADY(S_AXI_RREADY), .engine_busy(engine_busy), .engine_done(engine_done),
        .start(start), .mode(mode), .task_count(task_count), .irq(irq)
    );

    always #5 S_LITE_AXI_ACLK = ~S_LITE_AXI_ACLK;

    // Start pulse monitor: counts pulses and checks alignment with BVALID rising
    always @(negedge S_LITE_AXI_ACLK) begin
        if (start === 1'b1) begin
            start_cnt = start_cnt + 1;
            start_mode = mode;
            if (!(S_AXI_BVALID === 1'b1 && bvalid_prev === 1'b0)) start_misaligned = start_misaligned + 1;
        end
        bvalid_prev = S_AXI_BVALID;
    end

    task automatic step();
        @(posedge S_LITE_AXI_ACLK);
        #1;
    endtask

    task automatic handshake_aw_w(output bit ok);
        bit aw_hs, w_hs;
        ok = 1'b0;
        for (int n = 0; n < 20; n++) begin
            if (!S_AXI_AWVALID && !S_AXI_WVALID) begin
                ok = 1'b1;
                break;
            end
            aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
            w_hs  = S_AXI_WVALID && S_AXI_WREADY;
            step();
            if (aw_hs) S_AXI_AWVALID = 1'b0;
            if (w_hs)  S_AXI_WVALID  = 1'b0;
        end
        if (!S_AXI_AWVALID && !S_AXI_WVALID) ok = 1'b1;
    endtask

    task automatic finish_b(output logic [1:0] resp, output bit ok);
        ok = 1'b0;
        resp = 2'bxx;
        for (int n = 0; n < 20; n++) begin
            if (S_AXI_BVALID) begin
                resp = S_AXI_BRESP;
                S_AXI_BREADY = 1'b1;
                step();
                S_AXI_BREADY = 1'b0;
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic axi_write(input logic [3:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [1:0] resp);
        bit ok;
        S_AXI_AWADDR = addr; S_AXI_AWVALID = 1'b1;
        S_AXI_WDATA = data; S_AXI_WSTRB = strb; S_AXI_WVALID = 1'b1;
        handshake_aw_w(ok);
        if (!ok) begin
            chk_cnt++;
            $display("FAIL write_accept_timeout addr=%h", addr);
            S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
        end
        finish_b(resp, ok);
        if (!ok) begin
            chk_cnt++;
            $display("FAIL bvalid_timeout addr=%h", addr);
        end
    endtask

    task automatic axi_read(input logic [3:0] addr, output logic [31:0] data, output logic [1:0] resp);
        bit ok = 1'b0;
        data = 'x; resp = 'x;
        S_AXI_ARADDR = addr; S_AXI_ARVALID = 1'b1; S_AXI_RREADY = 1'b1;
        for (int n = 0; n < 20; n++) begin
            if (S_AXI_ARREADY) begin
                step();
                S_AXI_ARVALID = 1'b0;
                ok = 1'b1;
                break;
            end
            step();
        end
        S_AXI_ARVALID = 1'b0;
        if (ok) begin
            ok = 1'b0;
            for (int n = 0; n < 20; n++) begin
                if (S_AXI_RVALID) begin
                    data = S_AXI_RDATA; resp = S_AXI_RRESP;
                    step();
                    ok = 1'b1;
                    break;
                end
                step();
            end
        end
        S_AXI_RREADY = 1'b0;
        if (!ok) begin
            chk_cnt++;
            $display("FAIL read_timeout addr=%h", addr);
        end
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic [1:0] r;
        S_LITE_AXI_ARESETN = 1'b1;
        repeat (3) step();
        S_LITE_AXI_ARESETN = 1'b0;
        step();
        chk_cnt++;
        if ({start, irq, mode, task_count, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID, S_AXI_RVALID} !== 71'd0)
            $display("FAIL reset_outputs start=%b irq=%b mode=%b count=%h bvalid=%b rvalid=%b expected all 0",
                     start, irq, mode, task_count, S_AXI_BVALID, S_AXI_RVALID);
        else pass_cnt++;
        for (int a = 0; a < 4; a++) begin
            axi_read(4'(a * 4), d, r);
            chk_cnt++;
            if (d !== 32'd0 || r !== 2'b00) $display("FAIL reset_read addr=%0d rdata=%h rresp=%b expected 0/00", a * 4, d, r);
            else pass_cnt++;
        end
    endtask

    task automatic test_start();
        logic [1:0] r0, r1, r2;
        logic [31:0] d;
        logic [1:0] rr;
        axi_write(4'h8, 32'h3, 4'hF, r0);
        axi_write(4'hC, 32'h0, 4'hF, r1);
        start_cnt = 0; start_misaligned = 0;
        axi_write(4'h0, 32'h1, 4'hF, r2);
        chk_cnt++;
        if (task_count !== 64'd3) $display("FAIL start_count got=%h expected=3", task_count);
        else pass_cnt++;
        chk_cnt++;
        if (start_cnt !== 1 || start_misaligned !== 0 || start_mode !== 2'b00)
            $display("FAIL start_pulse pulses=%0d misaligned=%0d mode=%b expected 1/0/00", start_cnt, start_misaligned, start_mode);
        else pass_cnt++;
        chk_cnt++;
        if ({r0, r1, r2} !== 6'd0) $display("FAIL start_bresp got=%b %b %b expected 00", r0, r1, r2);
        else pass_cnt++;
        axi_read(4'h0, d, rr);
        chk_cnt++;
        if (d !== 32'h0) $display("FAIL start_reads_zero ctrl=%h expected=0", d);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        bit ok, w_hs;
        int bv_hi = 0, accepts = 0;
        logic [1:0] r;
        // W first, AW two cycles later
        S_AXI_WDATA = 32'h1234_5678; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1; S_AXI_BREADY = 1'b0;
        repeat (2) begin
            w_hs = S_AXI_WVALID && S_AXI_WREADY;
            step();
            if (w_hs) S_AXI_WVALID = 1'b0;
        end
        S_AXI_AWADDR = 4'h8; S_AXI_AWVALID = 1'b1;
        handshake_aw_w(ok);
        chk_cnt++;
        if (!ok) begin
            $display("FAIL b2b_accept_timeout awvalid=%b wvalid=%b expected both consumed", S_AXI_AWVALID, S_AXI_WVALID);
            S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
        end else pass_cnt++;
        for (int n = 0; n < 10 && !S_AXI_BVALID; n++) step();
        chk_cnt++;
        if (task_count[31:0] !== 32'h1234_5678) $display("FAIL b2b_update got=%h expected=12345678", task_count[31:0]);
        else pass_cnt++;
        // Second write offered while B is held off
        S_AXI_AWADDR = 4'h8; S_AXI_AWVALID = 1'b1;
        S_AXI_WDATA = 32'hAA; S_AXI_WVALID = 1'b1;
        for (int n = 0; n < 5; n++) begin
            if (S_AXI_BVALID) bv_hi++;
            if (S_AXI_AWREADY || S_AXI_WREADY) accepts++;
            step();
        end
        chk_cnt++;
        if (bv_hi !== 5 || accepts !== 0 || task_count[31:0] !== 32'h1234_5678)
            $display("FAIL b2b_hold bvalid_cycles=%0d accepts=%0d count=%h expected 5/0/12345678", bv_hi, accepts, task_count[31:0]);
        else pass_cnt++;
        S_AXI_BREADY = 1'b1;
        step();
        S_AXI_BREADY = 1'b0;
        handshake_aw_w(ok);
        if (!ok) begin S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; end
        finish_b(r, ok);
        chk_cnt++;
        if (!ok || r !== 2'b00 || task_count[31:0] !== 32'hAA)
            $display("FAIL b2b_second ok=%b bresp=%b count=%h expected 1/00/000000aa", ok, r, task_count[31:0]);
        else pass_cnt++;
    endtask

    task automatic test_irq();
        bit ok;
        logic [1:0] r;
        logic [31:0] d;
        axi_write(4'h0, 32'h8, 4'hF, r);
        engine_done = 1'b1;
        step();
        engine_done = 1'b0;
        chk_cnt++;
        if (irq !== 1'b0) $display("FAIL irq_latency irq=%b expected=0 one cycle after done", irq);
        else pass_cnt++;
        step();
        chk_cnt++;
        if (irq !== 1'b1) $display("FAIL irq_assert irq=%b expected=1", irq);
        else pass_cnt++;
        axi_read(4'h4, d, r);
        chk_cnt++;
        if (d !== 32'h2) $display("FAIL irq_status got=%h expected=2", d);
        else pass_cnt++;
        // W1C of DONE coinciding with a new completion
        S_AXI_AWADDR = 4'h4; S_AXI_AWVALID = 1'b1;
        S_AXI_WDATA = 32'h2; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
        handshake_aw_w(ok);
        engine_done = 1'b1;
        step();
        engine_done = 1'b0;
        finish_b(r, ok);
        axi_read(4'h4, d, r);
        chk_cnt++;
        if (d !== 32'h2 || irq !== 1'b1) $display("FAIL done_set_wins status=%h irq=%b expected 2/1", d, irq);
        else pass_cnt++;
        axi_write(4'h4, 32'h2, 4'hF, r);
        axi_read(4'h4, d, r);
        chk_cnt++;
        if (d !== 32'h0 || irq !== 1'b0) $display("FAIL done_clear status=%h irq=%b expected 0/0", d, irq);
        else pass_cnt++;
    endtask

    task automatic test_busy();
        logic [1:0] r0, r1, rr;
        logic [31:0] d_status, d_ctrl;
        engine_busy = 1'b1;
        start_cnt = 0;
        axi_write(4'h8, 32'h55, 4'hF, r0);
        axi_write(4'h0, 32'h3, 4'hF, r1);
        chk_cnt++;
        if (r0 !== 2'b10 || r1 !== 2'b10) $display("FAIL busy_bresp got=%b %b expected 10 10", r0, r1);
        else pass_cnt++;
        chk_cnt++;
        if (task_count[31:0] !== 32'hAA || start_cnt !== 0 || mode !== 2'b00)
            $display("FAIL busy_protect count=%h starts=%0d mode=%b expected aa/0/00", task_count[31:0], start_cnt, mode);
        else pass_cnt++;
        axi_read(4'h4, d_status, rr);
        axi_read(4'h0, d_ctrl, rr);
        chk_cnt++;
        if (d_status !== 32'h5 || d_ctrl !== 32'h8) $display("FAIL busy_regs status=%h ctrl=%h expected 5/8", d_status, d_ctrl);
        else pass_cnt++;
        engine_busy = 1'b0;
        axi_write(4'h4, 32'h4, 4'hF, r0);
    endtask

    task automatic test_zero_count();
        logic [1:0] r, rr;
        logic [31:0] d;
        axi_write(4'h8, 32'h0, 4'hF, r);
        axi_write(4'hC, 32'h0, 4'hF, r);
        start_cnt = 0;
        axi_write(4'h0, 32'h1, 4'hF, r);
        axi_read(4'h4, d, rr);
        chk_cnt++;
        if (r !== 2'b10 || start_cnt !== 0 || d !== 32'h4)
            $display("FAIL zero_count bresp=%b starts=%0d status=%h expected 10/0/4", r, start_cnt, d);
        else pass_cnt++;
        axi_write(4'h4, 32'h4, 4'hF, r);
        axi_read(4'h4, d, rr);
        chk_cnt++;
        if (d !== 32'h0 || r !== 2'b00) $display("FAIL err_clear status=%h bresp=%b expected 0/00", d, r);
        else pass_cnt++;
    endtask

    task automatic test_mode_start();
        logic [1:0] r, rr;
        logic [31:0] d;
        engine_done = 1'b1;
        step();
        engine_done = 1'b0;
        axi_write(4'h8, 32'h2, 4'h1, r);
        start_cnt = 0; start_misaligned = 0;
        axi_write(4'h0, 32'h5, 4'hF, r);
        chk_cnt++;
        if (r !== 2'b00 || start_cnt !== 1 || start_misaligned !== 0 || start_mode !== 2'b10)
            $display("FAIL mode_start bresp=%b starts=%0d misaligned=%0d mode=%b expected 00/1/0/10",
                     r, start_cnt, start_misaligned, start_mode);
        else pass_cnt++;
        axi_read(4'h4, d, rr);
        chk_cnt++;
        if (d !== 32'h0 || task_count !== 64'd2) $display("FAIL start_clears_done status=%h count=%h expected 0/2", d, task_count);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int bv = 0;
        S_AXI_AWADDR = 4'h8; S_AXI_AWVALID = 1'b1;
        S_AXI_WDATA = 32'h77; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
        for (int n = 0; n < 10 && !S_AXI_AWREADY; n++) step();
        #2;
        S_LITE_AXI_ARESETN = 1'b1;
        #1;
        chk_cnt++;
        if (S_AXI_AWREADY !== 1'b0 || S_AXI_WREADY !== 1'b0 || mode !== 2'b00)
            $display("FAIL async_reset awready=%b wready=%b mode=%b expected 0/0/00", S_AXI_AWREADY, S_AXI_WREADY, mode);
        else pass_cnt++;
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
        step();
        S_LITE_AXI_ARESETN = 1'b0;
        S_AXI_BREADY = 1'b1;
        for (int n = 0; n < 4; n++) begin
            if (S_AXI_BVALID) bv++;
            step();
        end
        S_AXI_BREADY = 1'b0;
        chk_cnt++;
        if (bv !== 0 || task_count !== 64'd0) $display("FAIL reset_abort bvalid_cycles=%0d count=%h expected 0/0", bv, task_count);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_start();
        test_back_to_back();
        test_irq();
        test_busy();
        test_zero_count();
        test_mode_start();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
